// File: rtl/threshold_ram_writer.sv
// Raster-order writer of threshold bytes into a single-port RAM.
// Define THRESHOLD_WRITER_CHECKSUM_EN to add the oChecksum accumulator.
module threshold_ram_writer #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iStart,
  input  logic [7:0]             iData,
  input  logic                   iValid,
  output logic                   oReady,
  output logic                   oWe,
  output logic [ADDR_WIDTH-1:0]  oAddress,
  output logic [7:0]             oWdata,
  output logic [WIDTH_BITS-1:0]  oCol,
  output logic [HEIGHT_BITS-1:0] oRow,
  output logic                   oBusy,
  output logic                   oDone
`ifdef THRESHOLD_WRITER_CHECKSUM_EN
  ,
  output logic [15:0]            oChecksum
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  state_t                 state_q;
  logic [WIDTH_BITS-1:0]  col_q;
  logic [HEIGHT_BITS-1:0] row_q;
  logic                   we_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [7:0]             wdata_q;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic                   accept;
  logic                   col_last;
  logic                   row_last;

  assign accept   = iValid && (state_q == WRITE);
  assign col_last = &col_q;
  assign row_last = &row_q;
  assign addr_d   = (ADDR_WIDTH'(row_q) << WIDTH_BITS)
                  + ADDR_WIDTH'(col_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (iStart) begin
            state_q <= WRITE;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        WRITE: begin
          if (accept) begin
            we_q    <= 1'b1;
            addr_q  <= addr_d;
            wdata_q <= iData;
            col_q   <= col_q + 1'b1;
            if (col_last) begin
              row_q <= row_q + 1'b1;
              if (row_last) begin
                state_q <= DONE;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef THRESHOLD_WRITER_CHECKSUM_EN
  logic [15:0] sum_q;

  // Accumulates what the RAM actually sees, one cycle behind the write.
  always_ff @(posedge clock) begin
    if (reset) begin
      sum_q <= '0;
    end else if (iStart && (state_q == IDLE)) begin
      sum_q <= '0;
    end else if (we_q) begin
      sum_q <= sum_q + {8'h00, wdata_q};
    end
  end

  assign oChecksum = sum_q;
`endif

  assign oReady   = (state_q == WRITE);
  assign oBusy    = (state_q == WRITE) || (state_q == DONE);
  assign oDone    = (state_q == DONE);
  assign oWe      = we_q;
  assign oAddress = addr_q;
  assign oWdata   = wdata_q;
  assign oCol     = col_q;
  assign oRow     = row_q;

endmodule

// File: tb/tb_threshold_ram_writer.sv
// Randomised and directed bench for threshold_ram_writer (4x4 frame).
// Checksum checks are active when THRESHOLD_WRITER_CHECKSUM_EN is defined.
module tb_threshold_ram_writer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iStart = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       iValid = 1'b0;
  logic       oReady;
  logic       oWe;
  logic [3:0] oAddress;
  logic [7:0] oWdata;
  logic [1:0] oCol;
  logic [1:0] oRow;
  logic       oBusy;
  logic       oDone;
`ifdef THRESHOLD_WRITER_CHECKSUM_EN
  logic [15:0] oChecksum;
`endif

  threshold_ram_writer #(
    .WIDTH_BITS (2),
    .HEIGHT_BITS(2),
    .ADDR_WIDTH (4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .iStart  (iStart),
    .iData   (iData),
    .iValid  (iValid),
    .oReady  (oReady),
    .oWe     (oWe),
    .oAddress(oAddress),
    .oWdata  (oWdata),
    .oCol    (oCol),
    .oRow    (oRow),
    .oBusy   (oBusy),
    .oDone   (oDone)
`ifdef THRESHOLD_WRITER_CHECKSUM_EN
    ,
    .oChecksum(oChecksum)
`endif
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int done_cyc = -1;

  // Reference: phase 0 idle, 1 writing, 2 done; cnt = pixels taken so far.
  int          m_phase = 0;
  int          m_cnt   = 0;
  logic        m_we    = 1'b0;
  logic [3:0]  m_addr  = 4'd0;
  logic [7:0]  m_wd    = 8'd0;
  logic [15:0] m_sum   = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic model(input logic r, input logic s, input logic v,
                       input logic [7:0] d);
    if (r) begin
      m_phase = 0; m_cnt = 0; m_we = 0;
      m_addr = 0; m_wd = 0; m_sum = 0;
    end else begin
      if (m_phase == 0 && s) m_sum = 16'd0;
      else if (m_we) m_sum = m_sum + 16'(m_wd);
      m_we = 1'b0;
      if (m_phase == 0) begin
        if (s) begin m_phase = 1; m_cnt = 0; end
      end else if (m_phase == 1) begin
        if (v) begin
          m_we = 1'b1;
          m_addr = 4'(m_cnt);
          m_wd = d;
          m_cnt++;
          if (m_cnt == 16) begin m_cnt = 0; m_phase = 2; end
        end
      end else begin
        m_phase = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic s, input logic v,
                      input logic [7:0] d);
    reset = r; iStart = s; iValid = v; iData = d;
    @(posedge clock);
    #1;
    cyc++;
    model(r, s, v, d);
    if (oDone === 1'b1) done_cyc = cyc;
    chk("ready", oReady, m_phase == 1);
    chk("busy",  oBusy,  m_phase != 0);
    chk("done",  oDone,  m_phase == 2);
    chk("we",    oWe,    m_we);
    chk("addr",  oAddress, m_addr);
    chk("wdata", oWdata, m_wd);
    chk("col",   oCol,   m_cnt % 4);
    chk("row",   oRow,   m_cnt / 4);
`ifdef THRESHOLD_WRITER_CHECKSUM_EN
    chk("csum",  oChecksum, m_sum);
`endif
  endtask

  // mode: 0 continuous, 1 gapped, 2 start noise, 3 all 0xFF, 4 random
  task automatic frame(input int mode, output int lat);
    int st;
    int guard;
    logic [7:0] d;
    st = cyc;
    step(0, 1, 0, 8'h00);
    if (mode == 4) begin
      guard = 0;
      while (m_phase == 1 && guard < 400) begin
        step(0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
             8'($urandom));
        guard++;
      end
      chk("rand_timeout", guard < 400, 1);
    end else begin
      for (int i = 0; i < 16; i++) begin
        d = (mode == 3) ? 8'hFF : 8'(i);
        step(0, (mode == 2) && (i % 3 == 1), 1, d);
        if (mode == 0 && i == 3) begin
          chk("wrap_col", oCol, 0);
          chk("wrap_row", oRow, 1);
        end
        if (mode == 1 && i < 15) begin
          step(0, 0, 0, 8'($urandom));
          chk("gap_we", oWe, 0);
          chk("gap_col", oCol, (i + 1) % 4);
        end
      end
    end
    lat = done_cyc - st;
  endtask

  initial begin
    int lat;
    step(1, 0, 0, 8'h00);
    step(1, 1, 1, 8'h55);
    chk("rst_addr", oAddress, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'(8'hA0 + i));
    chk("idle_we", oWe, 0);

    frame(0, lat);
    chk("cont_lat", lat, 17);
    chk("last_addr", oAddress, 15);
    step(0, 0, 0, 8'h00);
`ifdef THRESHOLD_WRITER_CHECKSUM_EN
    chk("csum120", oChecksum, 120);
`endif
    step(0, 0, 0, 8'h00);

    frame(1, lat);
    chk("gap_lat", lat, 32);
    step(0, 1, 0, 8'h00);
    chk("done_start_busy", oBusy, 0);
    step(0, 0, 1, 8'h11);
    chk("after_done_we", oWe, 0);

    frame(2, lat);
    chk("noise_lat", lat, 17);
    step(0, 0, 0, 8'h00);

    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'h30 + i));
    step(1, 0, 1, 8'h99);
    chk("midrst_busy", oBusy, 0);
    step(0, 0, 1, 8'h77);
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h42);
    chk("restart_addr", oAddress, 0);
    for (int i = 1; i < 16; i++) step(0, 0, 1, 8'(i));
    step(0, 0, 0, 8'h00);

    frame(3, lat);
    step(0, 0, 0, 8'h00);
`ifdef THRESHOLD_WRITER_CHECKSUM_EN
    chk("csum_ff", oChecksum, 16'h0FF0);
`endif
    step(0, 0, 0, 8'h00);

    for (int f = 0; f < 4; f++) begin
      frame(4, lat);
      step(0, 0, 0, 8'h00);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/threshold_ram_writer.md
# threshold_ram_writer

Raster-order writer that stores a stream of computed threshold bytes into a single-port threshold RAM. Each accepted byte gets its (column, row) position, and the address is formed as row·2^WIDTH_BITS + col. The block sits between the adaptive-threshold compute pipeline and the threshold RAM. It fills one full frame per start pulse, so downstream readers can fetch thresholds by coordinate.

## Interface
- WIDTH_BITS, 8: log2 of image width (width 256).
- HEIGHT_BITS, 8: log2 of image height (height 256).
- ADDR_WIDTH, 16: RAM address width; must equal WIDTH_BITS+HEIGHT_BITS.

Ports:
- clock  in  1  single clock domain; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- iStart  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- iData  in  8  threshold byte for the current pixel.
- iValid  in  1  iData is valid.
- oReady  out  1  block accepts iData this cycle.
- oWe  out  1  RAM write enable, one cycle per accepted pixel.
- oAddress  out  ADDR_WIDTH  RAM write address.
- oWdata  out  8  RAM write data.
- oCol  out  WIDTH_BITS  column of the next pixel to be accepted.
- oRow  out  HEIGHT_BITS  row of the next pixel to be accepted.
- oBusy  out  1  high in WRITE and DONE.
- oDone  out  1  one-cycle pulse marking the frame's final write.
- oChecksum  out  16  present only with THRESHOLD_WRITER_CHECKSUM_EN.

## Operation
- FSM states: IDLE, WRITE, DONE. Reset puts the FSM in IDLE.
- IDLE
  - oReady=0.
  - iStart=1 → WRITE; col and row set to 0.
  - iValid is ignored.
- WRITE
  - oReady=1 (combinational decode of state only).
  - Accept happens when iValid & oReady.
  - On accept: register oAddress=(row<<WIDTH_BITS)+col, oWdata=iData, oWe=1 for the next cycle.
  - On accept, col increments. When col = 2^WIDTH_BITS−1, col wraps to 0 and row increments.
  - When the accepted pixel is col=max, row=max: go to DONE, and col and row wrap to 0.
  - iStart is ignored.
- DONE
  - Lasts exactly one cycle: oDone=1, oReady=0, then → IDLE.
  - iStart is ignored.
- With no accept in a cycle, oWe=0 the next cycle. oAddress and oWdata hold their last values.
- Address arithmetic is unsigned, ADDR_WIDTH bits, with no overflow by construction.
- Reset mid-frame: abandons the frame immediately. No further writes occur, and the partial RAM contents are left as written.

## Timing
- Reset values: oReady=0, oWe=0, oAddress=0, oWdata=0, oCol=0, oRow=0, oBusy=0, oDone=0, oChecksum=0.
- Start latency: iStart sampled in cycle t → oReady=1 in cycle t+1.
- Write latency: a pixel accepted in cycle k → oWe, oAddress and oWdata valid in cycle k+1.
- Frame latency: with N = 2^(WIDTH_BITS+HEIGHT_BITS) and iValid held high, accepts occur at t+1..t+N. oDone is high at t+N+1, coinciding with the last oWe. The FSM is back in IDLE at t+N+2.
- Back-to-back frames: the earliest honoured iStart is at t+N+2.
- Bubbles (iValid=0) stall the pointer with no penalty. Throughput is 1 pixel/cycle.

## Configuration
- THRESHOLD_WRITER_CHECKSUM_EN defined:
  - oChecksum exists.
  - Cleared to 0 when iStart is honoured.
  - Adds oWdata (mod 2^16) in each cycle oWe=1, registered.
  - Its final value is visible in the cycle after oDone and holds until the next start or reset.
- Not defined: no oChecksum port and no accumulator logic. All other behaviour is identical.

## Test plan
All scenarios use WIDTH_BITS=2, HEIGHT_BITS=2, ADDR_WIDTH=4 (16 pixels).
- Continuous frame: iStart, then iData=0..15 with iValid held high → 16 writes with oAddress=k and oWdata=k on consecutive cycles. oDone is high with the write to address 15. With the checksum enabled, oChecksum=120 after oDone.
- Gapped input: iValid alternates 1/0 over data 0..15 → the same 16 writes, oWe=0 in the cycles following gaps, oCol/oRow hold during gaps, and oDone arrives 15 cycles later than in the continuous case.
- Row wrap: after the pixel at col=3, row=0 is accepted → oCol=0, oRow=1, and the next write address is 4.
- Ignored controls:
  - iValid=1 in IDLE → no oWe.
  - iStart pulsed during WRITE → pointer is not reset.
  - iStart in the DONE cycle → FSM returns to IDLE, oBusy=0.
- Reset mid-frame: reset after 5 accepts → all outputs match their reset values next cycle. A new frame then writes address 0 first.
- Checksum saturation check: 16 bytes of 0xFF → oChecksum=0x0FF0. Built without the macro, the design elaborates with no oChecksum port.
